pipe_phy_control: RTL and testbench



---
 rtl/pipe_phy_control.sv | 186 ++++++++++++++++++
 tb/tb_pipe_phy_control.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_phy_control.sv
// PIPE PHY-side control responder: power states, receiver detect, loopback.
// Optional PIPE_PHY_PROTO_CHECK_EN adds a sticky proto_err output.
module pipe_phy_control #(
  parameter int RESET_CYCLES   = 4,
  parameter int DETECT_LATENCY = 8,
  parameter int PWR_LATENCY    = 4,
  parameter int CNT_W          = 8
) (
  input  logic       pclk,
  input  logic       reset_n,
  input  logic [3:0] PowerDown,
  input  logic       TxDetectRx_Loopback,
  input  logic       TxElecIdle,
  input  logic       rx_present,
  output logic       PhyStatus,
  output logic [2:0] RxStatus,
  output logic       RxElecIdle,
  output logic       loopback_active,
  output logic [3:0] power_state
`ifdef PIPE_PHY_PROTO_CHECK_EN
  ,
  output logic       proto_err
`endif
);

  typedef enum logic [2:0] {
    RST_WAIT,
    IDLE,
    PWR_CHG,
    DETECT,
    STATUS
  } state_t;

  localparam int RST_L = (RESET_CYCLES   < 1) ? 1 : RESET_CYCLES;
  localparam int DET_L = (DETECT_LATENCY < 1) ? 1 : DETECT_LATENCY;
  localparam int PWR_L = (PWR_LATENCY    < 1) ? 1 : PWR_LATENCY;

  localparam logic [CNT_W-1:0] RST_TERM = CNT_W'(RST_L - 1);
  localparam logic [CNT_W-1:0] DET_TERM = CNT_W'(DET_L - 1);
  localparam logic [CNT_W-1:0] PWR_TERM = CNT_W'(PWR_L - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       target_q, target_d;
  logic [3:0]       pwr_q, pwr_d;
  logic             done_q, done_d;
  logic             phy_q, phy_d;
  logic [2:0]       rxs_q, rxs_d;
  logic             eidle_q, eidle_d;
  logic             lpbk_q, lpbk_d;

  logic pd_legal;
  logic pd_change;
  logic det_req;

  assign pd_legal  = (PowerDown[3:2] == 2'b00);
  assign pd_change = pd_legal && (PowerDown != pwr_q);
  assign det_req   = TxDetectRx_Loopback && (pwr_q == 4'd2)
                   && TxElecIdle && !done_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    pwr_d    = pwr_q;
    done_d   = done_q;
    phy_d    = phy_q;
    rxs_d    = rxs_q;
    lpbk_d   = (pwr_q == 4'd0) && TxDetectRx_Loopback && !TxElecIdle;
    eidle_d  = (pwr_q != 4'd0) || !rx_present;
    unique case (state_q)
      RST_WAIT: begin
        phy_d = 1'b1;
        if (cnt_q == RST_TERM) begin
          phy_d   = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (!TxDetectRx_Loopback) done_d = 1'b0;
        if (pd_change) begin
          target_d = PowerDown;
          cnt_d    = '0;
          state_d  = PWR_CHG;
        end else if (det_req) begin
          cnt_d   = '0;
          state_d = DETECT;
        end
      end
      PWR_CHG: begin
        if (cnt_q == PWR_TERM) begin
          pwr_d   = target_q;
          phy_d   = 1'b1;
          cnt_d   = '0;
          state_d = STATUS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DETECT: begin
        if (cnt_q == DET_TERM) begin
          rxs_d   = rx_present ? 3'b011 : 3'b000;
          done_d  = 1'b1;
          phy_d   = 1'b1;
          cnt_d   = '0;
          state_d = STATUS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STATUS: begin
        phy_d   = 1'b0;
        rxs_d   = 3'b000;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = RST_WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= RST_WAIT;
      cnt_q    <= '0;
      target_q <= 4'd2;
      pwr_q    <= 4'd2;
      done_q   <= 1'b0;
      phy_q    <= 1'b1;
      rxs_q    <= 3'b000;
      eidle_q  <= 1'b1;
      lpbk_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      pwr_q    <= pwr_d;
      done_q   <= done_d;
      phy_q    <= phy_d;
      rxs_q    <= rxs_d;
      eidle_q  <= eidle_d;
      lpbk_q   <= lpbk_d;
    end
  end

  assign PhyStatus       = phy_q;
  assign RxStatus        = rxs_q;
  assign RxElecIdle      = eidle_q;
  assign loopback_active = lpbk_q;
  assign power_state     = pwr_q;

`ifdef PIPE_PHY_PROTO_CHECK_EN
  logic [3:0] pd_q, pd_d;
  logic       err_q, err_d;

  // pd_q holds last cycle's PowerDown so a change inside DETECT is visible
  always_comb begin
    pd_d  = PowerDown;
    err_d = err_q;
    if (state_q != RST_WAIT) begin
      if ((state_q == IDLE) && !pd_legal) err_d = 1'b1;
      if ((state_q == DETECT) && (PowerDown != pd_q)) err_d = 1'b1;
      if (TxDetectRx_Loopback && (pwr_q == 4'd2) && !TxElecIdle)
        err_d = 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      pd_q  <= 4'd2;
      err_q <= 1'b0;
    end else begin
      pd_q  <= pd_d;
      err_q <= err_d;
    end
  end

  assign proto_err = err_q;
`endif

endmodule

// File: tb/tb_pipe_phy_control.sv
// Directed self-checking bench for pipe_phy_control.
// Outputs are sampled on the falling edge of pclk.
module tb_pipe_phy_control;

  logic       pclk = 1'b0;
  logic       reset_n;
  logic [3:0] PowerDown;
  logic       TxDetectRx_Loopback;
  logic       TxElecIdle;
  logic       rx_present;
  logic       PhyStatus;
  logic [2:0] RxStatus;
  logic       RxElecIdle;
  logic       loopback_active;
  logic [3:0] power_state;
`ifdef PIPE_PHY_PROTO_CHECK_EN
  logic       proto_err;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int n;

  always #5 pclk = ~pclk;

  pipe_phy_control dut (
    .pclk                (pclk),
    .reset_n             (reset_n),
    .PowerDown           (PowerDown),
    .TxDetectRx_Loopback (TxDetectRx_Loopback),
    .TxElecIdle          (TxElecIdle),
    .rx_present          (rx_present),
    .PhyStatus           (PhyStatus),
    .RxStatus            (RxStatus),
    .RxElecIdle          (RxElecIdle),
    .loopback_active     (loopback_active),
`ifdef PIPE_PHY_PROTO_CHECK_EN
    .proto_err           (proto_err),
`endif
    .power_state         (power_state)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // edges until PhyStatus is seen high; budget+1 if never
  task automatic wait_status(input int budget, output int cnt);
    cnt = 0;
    while (cnt <= budget) begin
      @(negedge pclk);
      cnt++;
      if (PhyStatus) break;
    end
  endtask

  task automatic count_pulses(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(negedge pclk);
      if (PhyStatus) cnt++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_phy"},   32'(PhyStatus), 32'd1);
    chk({tag, "_rxs"},   32'(RxStatus), 32'd0);
    chk({tag, "_eidle"}, 32'(RxElecIdle), 32'd1);
    chk({tag, "_lpbk"},  32'(loopback_active), 32'd0);
    chk({tag, "_pwr"},   32'(power_state), 32'd2);
  endtask

  task automatic release_reset(input string tag);
    @(negedge pclk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      chk({tag, "_phy_hi"}, 32'(PhyStatus), 32'd1);
    end
    @(negedge pclk);
    chk({tag, "_phy_lo"}, 32'(PhyStatus), 32'd0);
  endtask

  initial begin
    reset_n             = 1'b0;
    PowerDown           = 4'd2;
    TxDetectRx_Loopback = 1'b0;
    TxElecIdle          = 1'b1;
    rx_present          = 1'b1;
    repeat (3) @(negedge pclk);
    check_reset_vals("rst");
    release_reset("rel");
    chk("rel_pwr", 32'(power_state), 32'd2);

    // detect with receiver present
    TxDetectRx_Loopback = 1'b1;
    wait_status(20, n);
    chk("det1_lat", 32'(n), 32'd9);
    chk("det1_rxs", 32'(RxStatus), 32'd3);
    @(negedge pclk);
    chk("det1_phy_lo", 32'(PhyStatus), 32'd0);
    chk("det1_rxs_lo", 32'(RxStatus), 32'd0);
    count_pulses(20, n);
    chk("det1_hold", 32'(n), 32'd0);
    TxDetectRx_Loopback = 1'b0;
    repeat (2) @(negedge pclk);

    // detect with no receiver
    rx_present          = 1'b0;
    TxDetectRx_Loopback = 1'b1;
    wait_status(20, n);
    chk("det0_lat", 32'(n), 32'd9);
    chk("det0_rxs", 32'(RxStatus), 32'd0);
    count_pulses(12, n);
    chk("det0_hold", 32'(n), 32'd0);
    TxDetectRx_Loopback = 1'b0;
    rx_present          = 1'b1;
    repeat (2) @(negedge pclk);

    // P1 -> P0, then loopback
    PowerDown = 4'd0;
    wait_status(20, n);
    chk("p0_lat", 32'(n), 32'd5);
    chk("p0_pwr", 32'(power_state), 32'd0);
    @(negedge pclk);
    chk("p0_phy_lo", 32'(PhyStatus), 32'd0);
    chk("p0_eidle", 32'(RxElecIdle), 32'd0);
    TxElecIdle          = 1'b0;
    TxDetectRx_Loopback = 1'b1;
    @(negedge pclk);
    chk("lpbk_on", 32'(loopback_active), 32'd1);
    count_pulses(10, n);
    chk("lpbk_nophy", 32'(n), 32'd0);
    TxDetectRx_Loopback = 1'b0;
    TxElecIdle          = 1'b1;
    @(negedge pclk);
    chk("lpbk_off", 32'(loopback_active), 32'd0);

    // back to P1
    PowerDown = 4'd2;
    wait_status(20, n);
    chk("p1_lat", 32'(n), 32'd5);
    chk("p1_pwr", 32'(power_state), 32'd2);
    @(negedge pclk);
    chk("p1_eidle", 32'(RxElecIdle), 32'd1);

    // power change and detect together: P2 wins, no detect after
    PowerDown           = 4'd3;
    TxDetectRx_Loopback = 1'b1;
    wait_status(20, n);
    chk("sim_lat", 32'(n), 32'd5);
    chk("sim_pwr", 32'(power_state), 32'd3);
    chk("sim_rxs", 32'(RxStatus), 32'd0);
    count_pulses(15, n);
    chk("sim_nodet", 32'(n), 32'd0);
    TxDetectRx_Loopback = 1'b0;
    @(negedge pclk);
`ifdef PIPE_PHY_PROTO_CHECK_EN
    chk("perr_clean", 32'(proto_err), 32'd0);
`endif

    // illegal code ignored
    PowerDown = 4'd7;
    count_pulses(10, n);
    chk("ill_nophy", 32'(n), 32'd0);
    chk("ill_pwr", 32'(power_state), 32'd3);
`ifdef PIPE_PHY_PROTO_CHECK_EN
    chk("ill_perr", 32'(proto_err), 32'd1);
`endif
    PowerDown = 4'd2;
    wait_status(20, n);
    chk("p1b_lat", 32'(n), 32'd5);
    chk("p1b_pwr", 32'(power_state), 32'd2);
    @(negedge pclk);

    // reset in the middle of a detect
    TxDetectRx_Loopback = 1'b1;
    repeat (4) @(negedge pclk);
    chk("mid_nophy", 32'(PhyStatus), 32'd0);
    reset_n = 1'b0;
    #1;
    check_reset_vals("mid");
`ifdef PIPE_PHY_PROTO_CHECK_EN
    chk("mid_perr", 32'(proto_err), 32'd0);
`endif
    TxDetectRx_Loopback = 1'b0;
    repeat (2) @(negedge pclk);
    release_reset("rel2");
    count_pulses(12, n);
    chk("rel2_nophy", 32'(n), 32'd0);
    chk("rel2_rxs", 32'(RxStatus), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
